// File: rtl/pellet_tracker.sv
// Pellet bitmap for the maze: loads a 40x30 layout from a 1-bit ROM, clears the pellet under
// Pac-Man once per frame, keeps score/pellets-left, and answers per-pixel dot queries for VGA.
module pellet_tracker #(
    parameter logic [15:0] PELLET_POINTS = 16'd10,
    parameter logic [3:0]  DOT_LO        = 4'd6,
    parameter logic [3:0]  DOT_HI        = 4'd9
) (
    input  logic        vga_clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        restart,
    output logic [10:0] init_addr,
    input  logic        init_data,
    output logic        pellet_pixel,
    output logic [15:0] score,
    output logic [10:0] pellets_left,
    output logic        eat_pulse,
    output logic        level_clear,
    output logic        busy
);

    localparam int unsigned NCELLS = 1200;
    localparam logic [10:0] LAST_IDX = 11'd1199;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CHECK = 2'd2,
        EAT   = 2'd3
    } state_t;

    function automatic logic in_grid(input logic [9:0] x, input logic [9:0] y);
        return (x < 10'd640) && (y < 10'd480);
    endfunction

    // idx = cy*40 + cx using shifts only; only meaningful for in-grid coordinates.
    function automatic logic [10:0] cell_idx(input logic [5:0] cx, input logic [5:0] cy);
        logic [10:0] x11;
        logic [10:0] y11;
        x11 = {5'd0, cx};
        y11 = {5'd0, cy};
        return (y11 << 5) + (y11 << 3) + x11;
    endfunction

    state_t            state_q, state_d;
    logic [10:0]       a_q, a_d;
    logic              wr_en_q, wr_en_d;
    logic [10:0]       wr_idx_q, wr_idx_d;
    logic [9:0]        bx_q, bx_d;
    logic [9:0]        by_q, by_d;
    logic              frame_clk_q;
    logic [15:0]       score_q, score_d;
    logic [10:0]       left_q, left_d;
    logic              clear_q, clear_d;
    logic              eat_q, eat_d;
    logic              pix_q, pix_d;
    logic [NCELLS-1:0] bitmap_q;

    logic              fedge;
    logic [10:0]       eat_idx;
    logic              eat_hit;
    logic [16:0]       score_sum;
    logic              bm_we;
    logic [10:0]       bm_widx;
    logic              bm_wdata;

    logic              r_in;
    logic [10:0]       r_idx;
    logic              r_bit;
    logic              r_dot_x;
    logic              r_dot_y;

    assign fedge     = frame_clk & ~frame_clk_q;
    assign eat_idx   = cell_idx(bx_q[9:4], by_q[9:4]);
    assign eat_hit   = in_grid(bx_q, by_q) ? bitmap_q[eat_idx] : 1'b0;
    assign score_sum = {1'b0, score_q} + {1'b0, PELLET_POINTS};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        wr_en_d  = 1'b0;
        wr_idx_d = wr_idx_q;
        bx_d     = bx_q;
        by_d     = by_q;
        score_d  = score_q;
        left_d   = left_q;
        clear_d  = clear_q;
        eat_d    = 1'b0;
        bm_we    = 1'b0;
        bm_widx  = wr_idx_q;
        bm_wdata = 1'b0;
        case (state_q)
            INIT: begin
                // Address issue runs one cycle ahead of the write because the ROM is registered.
                wr_en_d  = 1'b1;
                wr_idx_d = a_q;
                if (a_q != LAST_IDX) begin
                    a_d = a_q + 11'd1;
                end
                if (wr_en_q) begin
                    bm_we    = 1'b1;
                    bm_widx  = wr_idx_q;
                    bm_wdata = init_data;
                    if (init_data) begin
                        left_d = left_q + 11'd1;
                    end
                    if (wr_idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        wr_en_d = 1'b0;
                        if (left_d == 11'd0) begin
                            clear_d = 1'b1;
                        end
                    end
                end
            end
            IDLE: begin
                if (restart) begin
                    state_d = INIT;
                    a_d     = 11'd0;
                    left_d  = 11'd0;
                    clear_d = 1'b0;
                end else if (fedge) begin
                    state_d = CHECK;
                    bx_d    = BallX;
                    by_d    = BallY;
                end
            end
            CHECK: begin
                // Counters update on entry to EAT so they are visible together with eat_pulse.
                if (eat_hit) begin
                    state_d = EAT;
                    eat_d   = 1'b1;
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    left_d  = left_q - 11'd1;
                    if (left_q == 11'd1) begin
                        clear_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EAT: begin
                bm_we    = 1'b1;
                bm_widx  = eat_idx;
                bm_wdata = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = INIT;
                a_d     = 11'd0;
            end
        endcase
    end

    always_comb begin
        r_in    = in_grid(DrawX, DrawY);
        r_idx   = cell_idx(DrawX[9:4], DrawY[9:4]);
        r_bit   = r_in ? bitmap_q[r_idx] : 1'b0;
        r_dot_x = (DrawX[3:0] >= DOT_LO) && (DrawX[3:0] <= DOT_HI);
        r_dot_y = (DrawY[3:0] >= DOT_LO) && (DrawY[3:0] <= DOT_HI);
        pix_d   = (state_q != INIT) & r_bit & r_dot_x & r_dot_y;
    end

    always_ff @(posedge vga_clk) begin
        if (!Reset_n) begin
            state_q     <= INIT;
            a_q         <= 11'd0;
            wr_en_q     <= 1'b0;
            wr_idx_q    <= 11'd0;
            bx_q        <= 10'd0;
            by_q        <= 10'd0;
            frame_clk_q <= 1'b0;
            score_q     <= 16'd0;
            left_q      <= 11'd0;
            clear_q     <= 1'b0;
            eat_q       <= 1'b0;
            pix_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            wr_en_q     <= wr_en_d;
            wr_idx_q    <= wr_idx_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            frame_clk_q <= frame_clk;
            score_q     <= score_d;
            left_q      <= left_d;
            clear_q     <= clear_d;
            eat_q       <= eat_d;
            pix_q       <= pix_d;
        end
    end

    // Bitmap contents are not reset; every INIT pass rewrites all cells.
    always_ff @(posedge vga_clk) begin
        if (Reset_n && bm_we) begin
            bitmap_q[bm_widx] <= bm_wdata;
        end
    end

    assign init_addr    = a_q;
    assign pellet_pixel = pix_q;
    assign score        = score_q;
    assign pellets_left = left_q;
    assign eat_pulse    = eat_q;
    assign level_clear  = clear_q;
    assign busy         = (state_q == INIT);

endmodule

// File: tb/tb_pellet_tracker.sv
// Bench for pellet_tracker: directed plan steps plus random frames/queries checked against an
// array-based model of the pellet grid, score and level state.
module tb_pellet_tracker;

    logic        vga_clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic [9:0]  BallX = '0;
    logic [9:0]  BallY = '0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        restart = 1'b0;
    logic [10:0] init_addr;
    logic        init_data;
    logic        pellet_pixel;
    logic [15:0] score;
    logic [10:0] pellets_left;
    logic        eat_pulse;
    logic        level_clear;
    logic        busy;

    always #5 vga_clk = ~vga_clk;

    pellet_tracker dut (
        .vga_clk      (vga_clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .BallX        (BallX),
        .BallY        (BallY),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .restart      (restart),
        .init_addr    (init_addr),
        .init_data    (init_data),
        .pellet_pixel (pellet_pixel),
        .score        (score),
        .pellets_left (pellets_left),
        .eat_pulse    (eat_pulse),
        .level_clear  (level_clear),
        .busy         (busy)
    );

    // Layout ROM with one cycle of read latency.
    bit rom [0:1199];
    always @(posedge vga_clk) begin
        init_data <= (init_addr < 11'd1200) ? rom[init_addr] : 1'b0;
    end

    // Reference model of the grid.
    bit bm [0:1199];
    int m_score;
    int m_left;
    bit m_lc;

    int passes = 0;
    int checks = 0;

    task automatic tick();
        @(negedge vga_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic bit m_in(input int x, input int y);
        return (x < 640) && (y < 480);
    endfunction

    function automatic int m_idx(input int x, input int y);
        return (y / 16) * 40 + (x / 16);
    endfunction

    task automatic load_model();
        m_left = 0;
        for (int i = 0; i < 1200; i++) begin
            bm[i] = rom[i];
            m_left += int'(rom[i]);
        end
        m_lc = (m_left == 0);
    endtask

    task automatic do_reset(input string tag);
        Reset_n = 1'b0;
        tick();
        check({tag, " rst busy"}, 32'(busy), 32'd1);
        check({tag, " rst score"}, 32'(score), 32'd0);
        check({tag, " rst left"}, 32'(pellets_left), 32'd0);
        check({tag, " rst lc"}, 32'(level_clear), 32'd0);
        check({tag, " rst pulse"}, 32'(eat_pulse), 32'd0);
        check({tag, " rst pix"}, 32'(pellet_pixel), 32'd0);
        check({tag, " rst addr"}, 32'(init_addr), 32'd0);
        Reset_n = 1'b1;
        m_score = 0;
    endtask

    // Counts busy cycles starting from INIT cycle n0, then checks the loaded state.
    task automatic wait_init(input string tag, input int n0);
        int n;
        n = n0;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            tick();
        end
        load_model();
        check({tag, " init cycles"}, 32'(n), 32'd1201);
        check({tag, " left"}, 32'(pellets_left), 32'(m_left));
        check({tag, " lc"}, 32'(level_clear), 32'(m_lc));
        check({tag, " score"}, 32'(score), 32'(m_score));
        check({tag, " addr"}, 32'(init_addr), 32'd1199);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic frame(input string tag, input int x, input int y, input bit chk);
        bit hit;
        int idx;
        idx = m_idx(x, y);
        hit = m_in(x, y) && bm[idx];
        BallX = 10'(x);
        BallY = 10'(y);
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        if (chk) check({tag, " pulse early"}, 32'(eat_pulse), 32'd0);
        tick();
        if (hit) begin
            bm[idx] = 1'b0;
            m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
            m_left--;
            if (m_left == 0) m_lc = 1'b1;
        end
        if (chk) begin
            check({tag, " pulse"}, 32'(eat_pulse), 32'(hit));
            check({tag, " score"}, 32'(score), 32'(m_score));
            check({tag, " left"}, 32'(pellets_left), 32'(m_left));
            check({tag, " lc"}, 32'(level_clear), 32'(m_lc));
        end
        tick();
        if (chk) check({tag, " pulse end"}, 32'(eat_pulse), 32'd0);
    endtask

    task automatic query(input string tag, input int x, input int y);
        bit exp;
        int ox;
        int oy;
        ox = x % 16;
        oy = y % 16;
        exp = m_in(x, y) && bm[m_idx(x, y)] && ox >= 6 && ox <= 9 && oy >= 6 && oy <= 9;
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
        check(tag, 32'(pellet_pixel), 32'(exp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x;
        int y;
        int c;

        // Even-index layout.
        for (int i = 0; i < 1200; i++) rom[i] = (i % 2 == 0);
        do_reset("boot");
        wait_init("boot", 0);

        frame("eat660", 328, 264, 1'b1);
        frame("reeat660", 328, 264, 1'b1);

        query("pix eaten", 327, 263);
        query("pix odd", 311, 263);
        query("pix 662 in", 359, 263);
        query("pix 662 off", 364, 263);

        frame("offgrid", 650, 100, 1'b1);
        query("pix offgrid", 645, 263);

        // Random frames and queries, half aimed at pellet cells.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                c = 2 * int'($urandom_range(0, 599));
                x = (c % 40) * 16 + int'($urandom_range(0, 15));
                y = (c / 40) * 16 + int'($urandom_range(0, 15));
            end else begin
                x = int'($urandom_range(0, 700));
                y = int'($urandom_range(0, 540));
            end
            frame("rnd frame", x, y, 1'b1);
        end
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                c = int'($urandom_range(0, 1199));
                x = (c % 40) * 16 + int'($urandom_range(4, 11));
                y = (c / 40) * 16 + int'($urandom_range(4, 11));
            end else begin
                x = int'($urandom_range(0, 700));
                y = int'($urandom_range(0, 540));
            end
            query("rnd pix", x, y);
        end

        // Single-pellet layout, with a reset landing mid-INIT.
        for (int i = 0; i < 1200; i++) rom[i] = (i == 0);
        do_reset("single");
        for (int k = 0; k < 500; k++) tick();
        do_reset("midinit");
        wait_init("midinit", 0);
        frame("last pellet", 5, 5, 1'b1);
        do_restart();
        wait_init("restart", 0);

        // Empty layout: level_clear comes straight out of INIT; render is blanked while busy.
        for (int i = 0; i < 1200; i++) rom[i] = 1'b0;
        do_restart();
        DrawX = 10'd8;
        DrawY = 10'd8;
        tick();
        check("pix busy", 32'(pellet_pixel), 32'd0);
        wait_init("empty", 1);

        // Saturation: eat through full layouts until the score reaches 65530.
        for (int i = 0; i < 1200; i++) rom[i] = 1'b1;
        do_restart();
        wait_init("full", 0);
        while (m_score < 65530) begin
            if (m_left == 0) begin
                do_restart();
                wait_init("reload", 0);
            end
            for (int i = 0; i < 1200 && m_score < 65530; i++) begin
                if (bm[i]) frame("bulk", (i % 40) * 16 + 8, (i / 40) * 16 + 8, 1'b0);
            end
        end
        check("pre sat score", 32'(score), 32'(m_score));
        check("pre sat left", 32'(pellets_left), 32'(m_left));
        if (m_left == 0) begin
            do_restart();
            wait_init("reload", 0);
        end
        for (int k = 0; k < 2; k++) begin
            c = 0;
            while (c < 1199 && !bm[c]) c++;
            frame("sat", (c % 40) * 16 + 3, (c / 40) * 16 + 12, 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
